// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter/sequencer sharing one iterative divider among NREQ requesters.
// Optional DIV_ARB_ZERO_BYPASS_EN answers zero divisors locally without starting the divider.
module div_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] num,
  input  logic [NREQ*W-1:0] den,
  output logic [NREQ-1:0]   done,
  output logic              er,
  output logic [W-1:0]      Coc,
  output logic [W-1:0]      Res,
  output logic              busy,
  output logic [2:0]        gnt_id,
  output logic              div_start,
  output logic [W-1:0]      div_num,
  output logic [W-1:0]      div_den,
  input  logic              div_done,
  input  logic              div_er,
  input  logic [W-1:0]      div_coc,
  input  logic [W-1:0]      div_res
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t       state_q, state_d;
  logic [2:0]   ptr_q, ptr_d;
  logic [2:0]   gnt_q, gnt_d;
  logic [W-1:0] num_q, num_d;
  logic [W-1:0] den_q, den_d;
  logic [W-1:0] coc_q, coc_d;
  logic [W-1:0] res_q, res_d;
  logic         er_q, er_d;

  logic         hi_vld, lo_vld, pick_vld;
  logic [2:0]   hi_idx, lo_idx, pick_idx;
  logic [W-1:0] pick_num, pick_den;
  logic         zero_den;

  // Descending scan leaves the lowest set index; hi_* restricts it to indices at or above ptr.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        lo_vld = 1'b1;
        lo_idx = 3'(k);
        if (k >= int'(ptr_q)) begin
          hi_vld = 1'b1;
          hi_idx = 3'(k);
        end
      end
    end
    pick_vld = lo_vld;
    pick_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    pick_num = '0;
    pick_den = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_idx == 3'(k)) begin
        pick_num = num[k*W +: W];
        pick_den = den[k*W +: W];
      end
    end
  end

`ifdef DIV_ARB_ZERO_BYPASS_EN
  assign zero_den = (den_q == '0);
`else
  assign zero_den = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    num_d   = num_q;
    den_d   = den_q;
    coc_d   = coc_q;
    res_d   = res_q;
    er_d    = er_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_idx;
          num_d   = pick_num;
          den_d   = pick_den;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (zero_den) begin
          er_d    = 1'b1;
          coc_d   = '0;
          res_d   = '0;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (div_done) begin
          coc_d   = div_coc;
          res_d   = div_res;
          er_d    = div_er;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        ptr_d   = (gnt_q == 3'(NREQ - 1)) ? 3'd0 : gnt_q + 3'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      num_q   <= '0;
      den_q   <= '0;
      coc_q   <= '0;
      res_q   <= '0;
      er_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      num_q   <= num_d;
      den_q   <= den_d;
      coc_q   <= coc_d;
      res_q   <= res_d;
      er_q    <= er_d;
    end
  end

  // Outputs decode registered state only, so there is no input-to-output path.
  always_comb begin
    done = '0;
    if (state_q == S_RESP) begin
      for (int k = 0; k < NREQ; k++) begin
        if (gnt_q == 3'(k)) done[k] = 1'b1;
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign div_start = (state_q == S_ISSUE) && !zero_den;
  assign gnt_id    = gnt_q;
  assign div_num   = num_q;
  assign div_den   = den_q;
  assign Coc       = coc_q;
  assign Res       = res_q;
  assign er        = er_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a fixed-latency divider model (start to done = 5 cycles).
module tb_div_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LAT  = 5;

  logic              CLK;
  logic              RST;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] num;
  logic [NREQ*W-1:0] den;
  logic [NREQ-1:0]   done;
  logic              er;
  logic [W-1:0]      Coc;
  logic [W-1:0]      Res;
  logic              busy;
  logic [2:0]        gnt_id;
  logic              div_start;
  logic [W-1:0]      div_num;
  logic [W-1:0]      div_den;
  logic              div_done;
  logic              div_er;
  logic [W-1:0]      div_coc;
  logic [W-1:0]      div_res;

  logic              mdl_done;
  logic              stray;
  logic [W-1:0]      m_num, m_den;
  int                m_cnt;
  logic              m_act;

  int total = 0;
  int bad   = 0;
  int n;

  div_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .CLK(CLK), .RST(RST), .req(req), .num(num), .den(den),
    .done(done), .er(er), .Coc(Coc), .Res(Res), .busy(busy), .gnt_id(gnt_id),
    .div_start(div_start), .div_num(div_num), .div_den(div_den),
    .div_done(div_done), .div_er(div_er), .div_coc(div_coc), .div_res(div_res)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign div_done = mdl_done | stray;

  // Divider model: latches operands on start, strobes done LAT cycles later; shares RST.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_act    <= 1'b0;
      m_cnt    <= 0;
      m_num    <= '0;
      m_den    <= '0;
      mdl_done <= 1'b0;
      div_er   <= 1'b0;
      div_coc  <= '0;
      div_res  <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (div_start) begin
        m_num <= div_num;
        m_den <= div_den;
        m_cnt <= LAT - 1;
        m_act <= 1'b1;
      end else if (m_act) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_act    <= 1'b0;
          mdl_done <= 1'b1;
          div_er   <= (m_den == 0);
          div_coc  <= (m_den == 0) ? 8'hFF : m_num / m_den;
          div_res  <= (m_den == 0) ? m_num : m_num % m_den;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [W-1:0] nv, input logic [W-1:0] dv);
    num[k*W +: W] = nv;
    den[k*W +: W] = dv;
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (done != 0) begin
        cyc = i;
        break;
      end
    end
    chk("done_timeout", (cyc != 0), 1);
  endtask

  task automatic chk_resp(input string tag, input logic [3:0] exp_done, input logic [2:0] exp_gnt,
                          input logic [7:0] exp_coc, input logic [7:0] exp_res);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_gnt"}, gnt_id, exp_gnt);
    chk({tag, "_coc"}, Coc, exp_coc);
    chk({tag, "_res"}, Res, exp_res);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST   = 1'b1;
    req   = '0;
    num   = '0;
    den   = '0;
    stray = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start", div_start, 0);
    chk("rst_coc", Coc, 0);
    chk("rst_res", Res, 0);
    chk("rst_er", er, 0);
    chk("rst_gnt", gnt_id, 0);
    chk("rst_dnum", div_num, 0);
    chk("rst_dden", div_den, 0);
    RST = 1'b0;
    tick();

    // Single request: 100/7 = 14 r 2, done at cycle 7.
    set_op(0, 8'd100, 8'd7);
    req = 4'b0001;
    tick();
    chk("single_start_c1", div_start, 1);
    chk("single_busy_c1", busy, 1);
    chk("single_dnum", div_num, 100);
    chk("single_dden", div_den, 7);
    tick();
    chk("single_start_c2", div_start, 0);
    tick(); tick(); tick(); tick();
    chk("single_done_c6", done, 0);
    tick();
    chk_resp("single", 4'b0001, 3'd0, 8'd14, 8'd2);
    chk("single_er", er, 0);
    req = 4'b0000;
    tick();
    chk("single_idle", busy, 0);

    // Contention from a fresh pointer: grants 0,1,2,3,0.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    set_op(0, 8'd200, 8'd9);
    set_op(1, 8'd50,  8'd7);
    set_op(2, 8'd255, 8'd16);
    set_op(3, 8'd81,  8'd9);
    req = 4'b1111;
    wait_done(20, n);
    chk("cont0_lat", n, 7);
    chk_resp("cont0", 4'b0001, 3'd0, 8'd22, 8'd2);
    wait_done(20, n);
    chk("cont1_gap", n, 8);
    chk_resp("cont1", 4'b0010, 3'd1, 8'd7, 8'd1);
    wait_done(20, n);
    chk("cont2_gap", n, 8);
    chk_resp("cont2", 4'b0100, 3'd2, 8'd15, 8'd15);
    wait_done(20, n);
    chk_resp("cont3", 4'b1000, 3'd3, 8'd9, 8'd0);
    wait_done(20, n);
    chk_resp("cont4", 4'b0001, 3'd0, 8'd22, 8'd2);
    req = 4'b0000;
    tick();

    // Serve requester 2 to leave ptr=3, then 1001 must go 3 then 0.
    set_op(2, 8'd60, 8'd8);
    req = 4'b0100;
    wait_done(20, n);
    chk_resp("wrap_r2", 4'b0100, 3'd2, 8'd7, 8'd4);
    req = 4'b1001;
    wait_done(20, n);
    chk_resp("wrap_r3", 4'b1000, 3'd3, 8'd9, 8'd0);
    req = 4'b0001;
    wait_done(20, n);
    chk_resp("wrap_r0", 4'b0001, 3'd0, 8'd22, 8'd2);
    req = 4'b0000;
    tick();

    // Divide by zero on requester 1.
    set_op(1, 8'd50, 8'd0);
    req = 4'b0010;
    tick();
`ifdef DIV_ARB_ZERO_BYPASS_EN
    chk("dbz_start", div_start, 0);
    chk("dbz_busy", busy, 1);
    tick();
    chk_resp("dbz", 4'b0010, 3'd1, 8'd0, 8'd0);
    chk("dbz_er", er, 1);
`else
    chk("dbz_start", div_start, 1);
    wait_done(20, n);
    chk("dbz_lat", n, 6);
    chk_resp("dbz", 4'b0010, 3'd1, 8'hFF, 8'd50);
    chk("dbz_er", er, 1);
`endif
    req = 4'b0000;
    set_op(1, 8'd50, 8'd7);
    tick();

    // Reset during WAIT (ptr=2, requester 3 in flight).
    set_op(3, 8'd81, 8'd9);
    req = 4'b1000;
    tick(); tick(); tick();
    chk("mid_busy", busy, 1);
    chk("mid_gnt", gnt_id, 3);
    RST = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_start", div_start, 0);
    chk("arst_coc", Coc, 0);
    chk("arst_res", Res, 0);
    chk("arst_er", er, 0);
    chk("arst_gnt", gnt_id, 0);
    chk("arst_dnum", div_num, 0);
    req = 4'b0000;
    tick(); tick();
    chk("arst_hold_done", done, 0);
    RST = 1'b0;
    set_op(0, 8'd100, 8'd7);
    set_op(2, 8'd60, 8'd8);
    req = 4'b0101;
    tick();
    chk("post_rst_gnt", gnt_id, 0);
    wait_done(20, n);
    chk("post_rst_lat", n, 6);
    chk_resp("post_rst_r0", 4'b0001, 3'd0, 8'd14, 8'd2);
    req = 4'b0100;
    wait_done(20, n);
    chk_resp("post_rst_r2", 4'b0100, 3'd2, 8'd7, 8'd4);
    req = 4'b0000;
    tick();

    // Stray div_done in IDLE, operand change during WAIT.
    stray = 1'b1;
    tick();
    stray = 1'b0;
    chk("stray_busy", busy, 0);
    chk("stray_done", done, 0);
    chk("stray_coc", Coc, 7);
    tick();
    chk("stray_busy2", busy, 0);
    set_op(0, 8'd100, 8'd7);
    req = 4'b0001;
    tick();
    tick();
    set_op(0, 8'd3, 8'd1);
    tick();
    chk("hold_dnum", div_num, 100);
    chk("hold_dden", div_den, 7);
    wait_done(20, n);
    chk("hold_lat", n, 4);
    chk_resp("hold", 4'b0001, 3'd0, 8'd14, 8'd2);
    req = 4'b0000;
    tick();
    chk("end_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
